ev_bms_pack_controller: RTL and testbench
=========================================

EV_BMS_PACK_CONTROLLER -- requirements
Module: ev_bms_pack_controller

Interface
REQ-001 Parameter N_CELLS, default 3, number of series cells monitored (2..16).
REQ-002 Parameter ADC_W, default 12, width of every ADC quantity.
REQ-003 Parameters OV_TH 3400, UV_TH 2500, OC_TH 3000, OT_TH 3500: cell over/under-voltage, pack over-current and over-temperature thresholds, in ADC codes.
REQ-004 Parameter DEBOUNCE, default 3: consecutive evaluations needed to confirm a fault (1..15).
REQ-005 Parameter BAL_DELTA, default 50: cell-above-minimum threshold for passive balancing.
REQ-006 Parameter RETRY, default 2: consecutive clean evaluations required in COOLDOWN.
REQ-007 Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  synchronous active-low reset.
- sample_valid  in  1  a new sample is presented.
- sample_ready  out  1  block can accept a sample.
- cell_voltage_bus  in  N_CELLS*ADC_W  cell i occupies bits [i*ADC_W +: ADC_W].
- pack_current  in  ADC_W  pack current code.
- temperature  in  ADC_W  temperature code.
- fault_clear  in  1  operator request to leave FAULT.
- result_valid  out  1  one-cycle pulse: statistics updated.
- v_min, v_max  out  ADC_W  lowest and highest cell of the last sample.
- pack_sum  out  ADC_W+clog2(N_CELLS)  sum of cells, no overflow possible.
- balance_en  out  N_CELLS  per-cell bleed enable.
- charge_en, discharge_en  out  1  contactor enables.
- system_fault  out  1  high in FAULT.
- fault_code  out  4  one-hot {OT,OC,OV,UV} of the first confirmed fault.

Function
REQ-008 The scan sequencer SHALL have the states IDLE, SCAN and EVAL, with sample_ready = 1 only in IDLE.
REQ-009 On sample_valid && sample_ready, the block SHALL register all input samples and enter SCAN; the inputs are then ignored until the block returns to IDLE.
REQ-010 SCAN SHALL process one cell per cycle, index 0 to N_CELLS-1, accumulating min, max, sum and the per-cell OV (v > OV_TH) and UV (v < UV_TH) flags; a value equal to a threshold is not a fault.
REQ-011 EVAL SHALL last one cycle. It SHALL:
- evaluate OC (current > OC_TH) and OT (temperature > OT_TH);
- update the outputs and debounce counters;
- pulse result_valid;
- return to IDLE.
REQ-012 Latency: a sample accepted at edge T SHALL produce result_valid high in the cycle after edge T+N_CELLS+1; sample_ready SHALL be high again one cycle later.
REQ-013 Each of the four fault types SHALL have a saturating counter. On each EVAL the counter increments if the condition is true and clears to 0 if it is false; the fault is confirmed when the counter equals DEBOUNCE.
REQ-014 The protection FSM SHALL have the states INIT, NORMAL, FAULT and COOLDOWN, and SHALL change state only in EVAL cycles, except on reset.
REQ-015 INIT: enables 0. On a confirmed fault go to FAULT; on an evaluation with no raw condition go to NORMAL; otherwise stay in INIT.
REQ-016 NORMAL: charge_en = discharge_en = 1. On any confirmed fault go to FAULT.
REQ-017 On entering FAULT:
- enables go to 0 and system_fault goes to 1;
- fault_code latches the confirmed fault set;
- fault_code is not changed again until FAULT is left.
REQ-018 FAULT to COOLDOWN SHALL occur only in an EVAL cycle where fault_clear = 1 and no raw condition is present; fault_clear at any other time SHALL be ignored and not stored.
REQ-019 COOLDOWN:
- enables 0, system_fault 0;
- any raw condition returns to FAULT;
- RETRY consecutive clean evaluations go to NORMAL and clear fault_code.
REQ-020 Balancing:
- in NORMAL EVAL, balance_en[i] = 1 if cell_i - v_min > BAL_DELTA, else 0;
- in all other states balance_en = 0;
- balance_en holds between EVALs.
REQ-021 Simultaneous events: when a new confirmed fault and fault_clear occur in the same EVAL, the fault SHALL win (FAULT is held).
REQ-022 v_min, v_max, pack_sum and balance_en SHALL update only in EVAL.

Reset
REQ-023 While rst_n = 0 at a rising edge, the block SHALL go to these values:
- sequencer IDLE, FSM INIT;
- counters 0;
- sample_ready 1, result_valid 0;
- v_min, v_max, pack_sum 0;
- balance_en 0;
- charge_en, discharge_en, system_fault 0;
- fault_code 0.
REQ-024 A reset asserted during SCAN or EVAL SHALL abort the sample with no result_valid, and the block SHALL accept a new sample on the first cycle after reset is released.

Verification
REQ-025 Cells 3000/3100/3200, current 1000, temperature 2000, one sample -> result_valid 4 cycles after acceptance. Expected: v_min 3000, v_max 3200, pack_sum 9300, INIT to NORMAL, enables 1, balance_en 3'b110.
REQ-026 From NORMAL, cell 1 = 3401 for 3 samples -> FAULT at the third EVAL, enables 0, system_fault 1, fault_code OV. Cell 1 = 3400 (equal to threshold) for 10 samples -> no fault.
REQ-027 OV held for 2 samples, then 1 clean sample, then 2 OV samples -> no FAULT, because the debounce counter clears.
REQ-028 In FAULT with OT still present, pulse fault_clear -> stays FAULT. Then clean samples with fault_clear during EVAL -> COOLDOWN, then NORMAL after 2 clean EVALs, fault_code 0.
REQ-029 rst_n low for 1 cycle during cycle 2 of SCAN -> no result_valid, all outputs at reset values, sample_ready 1 next cycle.
REQ-030 N_CELLS = 8 with all cells 4095 -> pack_sum 32760, no overflow.

Source files
------------

// File: rtl/ev_bms_pack_controller_if.sv
// Sample/result bundle between a pack-controller and whoever feeds it samples.
// The master side presents samples and fault_clear; the slave side returns statistics and protection status.
interface ev_bms_pack_controller_if #(
  parameter int N_CELLS = 3,
  parameter int ADC_W   = 12
);
  localparam int SUM_W = ADC_W + $clog2(N_CELLS);

  logic                       sample_valid;
  logic                       sample_ready;
  logic [N_CELLS*ADC_W-1:0]   cell_voltage_bus;
  logic [ADC_W-1:0]           pack_current;
  logic [ADC_W-1:0]           temperature;
  logic                       fault_clear;
  logic                       result_valid;
  logic [ADC_W-1:0]           v_min;
  logic [ADC_W-1:0]           v_max;
  logic [SUM_W-1:0]           pack_sum;
  logic [N_CELLS-1:0]         balance_en;
  logic                       charge_en;
  logic                       discharge_en;
  logic                       system_fault;
  logic [3:0]                 fault_code;

  modport master (
    output sample_valid, cell_voltage_bus, pack_current, temperature, fault_clear,
    input  sample_ready, result_valid, v_min, v_max, pack_sum, balance_en,
           charge_en, discharge_en, system_fault, fault_code
  );

  modport slave (
    input  sample_valid, cell_voltage_bus, pack_current, temperature, fault_clear,
    output sample_ready, result_valid, v_min, v_max, pack_sum, balance_en,
           charge_en, discharge_en, system_fault, fault_code
  );
endinterface

// File: rtl/ev_bms_pack_controller.sv
// Battery pack controller: scans one cell per cycle, then debounces OV/UV/OC/OT faults
// and drives contactor enables, passive balancing and a latched fault code.
module ev_bms_pack_controller #(
  parameter int N_CELLS   = 3,
  parameter int ADC_W     = 12,
  parameter int OV_TH     = 3400,
  parameter int UV_TH     = 2500,
  parameter int OC_TH     = 3000,
  parameter int OT_TH     = 3500,
  parameter int DEBOUNCE  = 3,
  parameter int BAL_DELTA = 50,
  parameter int RETRY     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ev_bms_pack_controller_if.slave bus
);
  localparam int SUM_W = ADC_W + $clog2(N_CELLS);
  localparam int IDX_W = $clog2(N_CELLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);
  localparam logic [ADC_W-1:0] OV_CODE  = ADC_W'(OV_TH);
  localparam logic [ADC_W-1:0] UV_CODE  = ADC_W'(UV_TH);
  localparam logic [ADC_W-1:0] OC_CODE  = ADC_W'(OC_TH);
  localparam logic [ADC_W-1:0] OT_CODE  = ADC_W'(OT_TH);
  localparam logic [ADC_W-1:0] BAL_CODE = ADC_W'(BAL_DELTA);
  localparam logic [3:0]       DEB      = 4'(DEBOUNCE);
  localparam logic [7:0]       RETRY_N  = 8'(RETRY);

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_SCAN, SEQ_EVAL} seq_state_e;
  typedef enum logic [1:0] {PROT_INIT, PROT_NORMAL, PROT_FAULT, PROT_COOLDOWN} prot_state_e;

  seq_state_e         seq_q, seq_d;
  prot_state_e        prot_q, prot_d;
  logic [ADC_W-1:0]   cell_in [N_CELLS];
  logic [ADC_W-1:0]   cell_q [N_CELLS];
  logic [ADC_W-1:0]   cur_q, temp_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADC_W-1:0]   min_acc_q, min_acc_d, max_acc_q, max_acc_d;
  logic [SUM_W-1:0]   sum_acc_q, sum_acc_d;
  logic               ov_acc_q, ov_acc_d, uv_acc_q, uv_acc_d;
  logic [3:0][3:0]    cnt_q, cnt_d, cnt_next;
  logic [7:0]         retry_q, retry_d;
  logic               ready_q, ready_d, rvalid_q, rvalid_d;
  logic [ADC_W-1:0]   vmin_q, vmin_d, vmax_q, vmax_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [N_CELLS-1:0] bal_q, bal_d, bal_calc;
  logic [3:0]         code_q, code_d;
  logic [3:0]         raw, confirmed;
  logic               accept;
  logic [ADC_W-1:0]   scan_v;

  assign accept = bus.sample_valid && ready_q;
  assign scan_v = cell_q[idx_q];
  // Bit order matches fault_code: {OT, OC, OV, UV}.
  assign raw    = {temp_q > OT_CODE, cur_q > OC_CODE, ov_acc_q, uv_acc_q};

  for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
    assign cell_in[gi]  = bus.cell_voltage_bus[gi*ADC_W +: ADC_W];
    assign bal_calc[gi] = (cell_q[gi] - min_acc_q) > BAL_CODE;
  end

  always_comb begin
    cnt_next  = cnt_q;
    confirmed = '0;
    for (int k = 0; k < 4; k++) begin
      if (!raw[k])             cnt_next[k] = '0;
      else if (cnt_q[k] != DEB) cnt_next[k] = cnt_q[k] + 4'd1;
      confirmed[k] = (cnt_next[k] == DEB);
    end
  end

  always_comb begin
    seq_d     = seq_q;
    prot_d    = prot_q;
    idx_d     = idx_q;
    min_acc_d = min_acc_q;
    max_acc_d = max_acc_q;
    sum_acc_d = sum_acc_q;
    ov_acc_d  = ov_acc_q;
    uv_acc_d  = uv_acc_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    ready_d   = (seq_q == SEQ_IDLE) && !accept;
    rvalid_d  = 1'b0;
    vmin_d    = vmin_q;
    vmax_d    = vmax_q;
    sum_d     = sum_q;
    bal_d     = bal_q;
    code_d    = code_q;
    unique case (seq_q)
      SEQ_IDLE: begin
        if (accept) begin
          seq_d     = SEQ_SCAN;
          idx_d     = '0;
          min_acc_d = '1;
          max_acc_d = '0;
          sum_acc_d = '0;
          ov_acc_d  = 1'b0;
          uv_acc_d  = 1'b0;
        end
      end
      SEQ_SCAN: begin
        if (scan_v < min_acc_q) min_acc_d = scan_v;
        if (scan_v > max_acc_q) max_acc_d = scan_v;
        sum_acc_d = sum_acc_q + SUM_W'(scan_v);
        ov_acc_d  = ov_acc_q | (scan_v > OV_CODE);
        uv_acc_d  = uv_acc_q | (scan_v < UV_CODE);
        idx_d     = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) seq_d = SEQ_EVAL;
      end
      SEQ_EVAL: begin
        seq_d    = SEQ_IDLE;
        rvalid_d = 1'b1;
        vmin_d   = min_acc_q;
        vmax_d   = max_acc_q;
        sum_d    = sum_acc_q;
        cnt_d    = cnt_next;
        unique case (prot_q)
          PROT_INIT: begin
            if (|confirmed) begin
              prot_d = PROT_FAULT;
              code_d = confirmed;
            end else if (raw == 4'd0) begin
              prot_d = PROT_NORMAL;
            end
          end
          PROT_NORMAL: begin
            if (|confirmed) begin
              prot_d = PROT_FAULT;
              code_d = confirmed;
            end
          end
          // A confirmed fault implies a raw one, so a simultaneous clear can never leave FAULT.
          PROT_FAULT: begin
            if (bus.fault_clear && raw == 4'd0) begin
              prot_d  = PROT_COOLDOWN;
              retry_d = '0;
            end
          end
          PROT_COOLDOWN: begin
            if (raw != 4'd0) begin
              prot_d = PROT_FAULT;
            end else if (retry_q + 8'd1 == RETRY_N) begin
              prot_d  = PROT_NORMAL;
              code_d  = '0;
              retry_d = '0;
            end else begin
              retry_d = retry_q + 8'd1;
            end
          end
          default: prot_d = PROT_INIT;
        endcase
        bal_d = (prot_d == PROT_NORMAL) ? bal_calc : '0;
      end
      default: seq_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_q     <= SEQ_IDLE;
      prot_q    <= PROT_INIT;
      for (int k = 0; k < N_CELLS; k++) cell_q[k] <= '0;
      cur_q     <= '0;
      temp_q    <= '0;
      idx_q     <= '0;
      min_acc_q <= '0;
      max_acc_q <= '0;
      sum_acc_q <= '0;
      ov_acc_q  <= 1'b0;
      uv_acc_q  <= 1'b0;
      cnt_q     <= '0;
      retry_q   <= '0;
      ready_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      vmin_q    <= '0;
      vmax_q    <= '0;
      sum_q     <= '0;
      bal_q     <= '0;
      code_q    <= '0;
    end else begin
      seq_q     <= seq_d;
      prot_q    <= prot_d;
      if (accept) begin
        for (int k = 0; k < N_CELLS; k++) cell_q[k] <= cell_in[k];
        cur_q  <= bus.pack_current;
        temp_q <= bus.temperature;
      end
      idx_q     <= idx_d;
      min_acc_q <= min_acc_d;
      max_acc_q <= max_acc_d;
      sum_acc_q <= sum_acc_d;
      ov_acc_q  <= ov_acc_d;
      uv_acc_q  <= uv_acc_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      vmin_q    <= vmin_d;
      vmax_q    <= vmax_d;
      sum_q     <= sum_d;
      bal_q     <= bal_d;
      code_q    <= code_d;
    end
  end

  assign bus.sample_ready = ready_q;
  assign bus.result_valid = rvalid_q;
  assign bus.v_min        = vmin_q;
  assign bus.v_max        = vmax_q;
  assign bus.pack_sum     = sum_q;
  assign bus.balance_en   = bal_q;
  assign bus.charge_en    = (prot_q == PROT_NORMAL);
  assign bus.discharge_en = (prot_q == PROT_NORMAL);
  assign bus.system_fault = (prot_q == PROT_FAULT);
  assign bus.fault_code   = code_q;
endmodule

// File: tb/tb_ev_bms_pack_controller.sv
// Directed-vector bench for ev_bms_pack_controller: a table of samples with hand-computed
// expectations, plus hand-written reset-abort and 8-cell overflow sequences.
module tb_ev_bms_pack_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ev_bms_pack_controller_if #(.N_CELLS(3), .ADC_W(12)) b3 ();
  ev_bms_pack_controller_if #(.N_CELLS(8), .ADC_W(12)) b8 ();

  ev_bms_pack_controller #(.N_CELLS(3)) dut  (.clk(clk), .rst_n(rst_n), .bus(b3));
  ev_bms_pack_controller #(.N_CELLS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct {
    int c0, c1, c2, cur, temp;
    bit clr, idle_clr;
    int vmin, vmax, sum, bal;
    bit en, sf;
    int code;
  } vec_t;

  vec_t tbl[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(int c0, int c1, int c2, int cur, int temp, bit clr, bit idle_clr,
                              int vmin, int vmax, int sum, int bal, bit en, bit sf, int code);
    vec_t v;
    v.c0 = c0; v.c1 = c1; v.c2 = c2; v.cur = cur; v.temp = temp;
    v.clr = clr; v.idle_clr = idle_clr;
    v.vmin = vmin; v.vmax = vmax; v.sum = sum; v.bal = bal;
    v.en = en; v.sf = sf; v.code = code;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input vec_t v);
    check("v_min",        int'(b3.v_min),        v.vmin);
    check("v_max",        int'(b3.v_max),        v.vmax);
    check("pack_sum",     int'(b3.pack_sum),     v.sum);
    check("balance_en",   int'(b3.balance_en),   v.bal);
    check("charge_en",    int'(b3.charge_en),    int'(v.en));
    check("discharge_en", int'(b3.discharge_en), int'(v.en));
    check("system_fault", int'(b3.system_fault), int'(v.sf));
    check("fault_code",   int'(b3.fault_code),   v.code);
  endtask

  // One sample through the 3-cell DUT; fault_clear is raised only during the EVAL cycle when clr=1.
  task automatic send3(input int c0, input int c1, input int c2, input int cur, input int temp,
                       input bit clr);
    int waited;
    int lat;
    waited = 0;
    while (b3.sample_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_before_accept", int'(b3.sample_ready), 1);
    b3.cell_voltage_bus = {12'(c2), 12'(c1), 12'(c0)};
    b3.pack_current     = 12'(cur);
    b3.temperature      = 12'(temp);
    b3.sample_valid     = 1'b1;
    @(posedge clk); #1;
    b3.sample_valid     = 1'b0;
    b3.cell_voltage_bus = '1;
    b3.pack_current     = '1;
    b3.temperature      = '1;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 3) b3.fault_clear = clr;
      if (b3.result_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    b3.fault_clear = 1'b0;
    check("result_latency", lat, 4);
    check("ready_low_with_result", int'(b3.sample_ready), 0);
    @(posedge clk); #1;
    check("result_valid_one_cycle", int'(b3.result_valid), 0);
    check("ready_after_result", int'(b3.sample_ready), 1);
  endtask

  vec_t zero_v;
  vec_t v;
  int   lat8;

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    b3.sample_valid = 1'b0; b3.cell_voltage_bus = '0; b3.pack_current = '0;
    b3.temperature = '0; b3.fault_clear = 1'b0;
    b8.sample_valid = 1'b0; b8.cell_voltage_bus = '0; b8.pack_current = '0;
    b8.temperature = '0; b8.fault_clear = 1'b0;
    zero_v = mk(0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 0);

    // Cells c0,c1,c2 / current / temp / clr / idle_clr -> vmin vmax sum bal en sf code
    tbl.push_back(mk(3000, 3100, 3200, 1000, 2000, 1'b0, 1'b0, 3000, 3200, 9300, 'b110, 1'b1, 1'b0, 'b0000));
    for (int i = 0; i < 10; i++)   // every quantity exactly at its threshold
      tbl.push_back(mk(2500, 3400, 3000, 3000, 3500, 1'b0, 1'b0, 2500, 3400, 8900, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(3000, 3401, 3200, 1000, 2000, 1'b0, 1'b0, 3000, 3401, 9601, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(3000, 3401, 3200, 1000, 2000, 1'b0, 1'b0, 3000, 3401, 9601, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 2000, 1'b0, 1'b0, 3000, 3200, 9300, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(3000, 3401, 3200, 1000, 2000, 1'b0, 1'b0, 3000, 3401, 9601, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(3000, 3401, 3200, 1000, 2000, 1'b0, 1'b0, 3000, 3401, 9601, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(3000, 3401, 3200, 1000, 2000, 1'b0, 1'b0, 3000, 3401, 9601, 'b000, 1'b0, 1'b1, 'b0010));
    tbl.push_back(mk(3000, 3401, 3200, 1000, 2000, 1'b1, 1'b0, 3000, 3401, 9601, 'b000, 1'b0, 1'b1, 'b0010));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 2000, 1'b1, 1'b0, 3000, 3200, 9300, 'b000, 1'b0, 1'b0, 'b0010));
    tbl.push_back(mk(2499, 3100, 3200, 1000, 2000, 1'b1, 1'b0, 2499, 3200, 8799, 'b000, 1'b0, 1'b1, 'b0010));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 2000, 1'b1, 1'b0, 3000, 3200, 9300, 'b000, 1'b0, 1'b0, 'b0010));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 2000, 1'b0, 1'b0, 3000, 3200, 9300, 'b000, 1'b0, 1'b0, 'b0010));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 2000, 1'b0, 1'b0, 3000, 3200, 9300, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 3501, 1'b0, 1'b0, 3000, 3200, 9300, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 3501, 1'b0, 1'b0, 3000, 3200, 9300, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 3501, 1'b1, 1'b0, 3000, 3200, 9300, 'b000, 1'b0, 1'b1, 'b1000));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 3501, 1'b1, 1'b0, 3000, 3200, 9300, 'b000, 1'b0, 1'b1, 'b1000));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 2000, 1'b0, 1'b1, 3000, 3200, 9300, 'b000, 1'b0, 1'b1, 'b1000));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 2000, 1'b1, 1'b0, 3000, 3200, 9300, 'b000, 1'b0, 1'b0, 'b1000));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 2000, 1'b0, 1'b0, 3000, 3200, 9300, 'b000, 1'b0, 1'b0, 'b1000));
    tbl.push_back(mk(3000, 3100, 3200, 1000, 2000, 1'b0, 1'b0, 3000, 3200, 9300, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(2499, 3401, 3200, 3001, 2000, 1'b0, 1'b0, 2499, 3401, 9100, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(2499, 3401, 3200, 3001, 2000, 1'b0, 1'b0, 2499, 3401, 9100, 'b110, 1'b1, 1'b0, 'b0000));
    tbl.push_back(mk(2499, 3401, 3200, 3001, 2000, 1'b0, 1'b0, 2499, 3401, 9100, 'b000, 1'b0, 1'b1, 'b0111));

    repeat (3) @(posedge clk);
    #1;
    check("reset_sample_ready", int'(b3.sample_ready), 1);
    check("reset_result_valid", int'(b3.result_valid), 0);
    check_out(zero_v);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (v.idle_clr) begin
        b3.fault_clear = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b3.fault_clear = 1'b0;
      end
      send3(v.c0, v.c1, v.c2, v.cur, v.temp, v.clr);
      check_out(v);
      $display("txn %0d: cells=%0d/%0d/%0d cur=%0d temp=%0d clr=%0b -> vmin=%0d vmax=%0d sum=%0d bal=%b en=%0b sf=%0b code=%b",
               i, v.c0, v.c1, v.c2, v.cur, v.temp, v.clr, b3.v_min, b3.v_max, b3.pack_sum,
               b3.balance_en, b3.charge_en, b3.system_fault, b3.fault_code);
    end

    // Reset pulse in the second SCAN cycle aborts the sample.
    b3.cell_voltage_bus = {12'd3200, 12'd3100, 12'd3000};
    b3.pack_current     = 12'd1000;
    b3.temperature      = 12'd2000;
    b3.sample_valid     = 1'b1;
    @(posedge clk); #1;
    b3.sample_valid = 1'b0;
    check("scan_ready_low", int'(b3.sample_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_sample_ready", int'(b3.sample_ready), 1);
    check("abort_result_valid", int'(b3.result_valid), 0);
    check_out(zero_v);
    $display("txn abort: reset during scan, ready=%0b rv=%0b sf=%0b code=%b",
             b3.sample_ready, b3.result_valid, b3.system_fault, b3.fault_code);

    // Raw OV on the first evaluation keeps INIT; a clean one then reaches NORMAL.
    send3(3000, 3401, 3200, 1000, 2000, 1'b0);
    check_out(mk(0, 0, 0, 0, 0, 1'b0, 1'b0, 3000, 3401, 9601, 'b000, 1'b0, 1'b0, 'b0000));
    $display("txn init_hold: en=%0b sf=%0b bal=%b", b3.charge_en, b3.system_fault, b3.balance_en);
    send3(3000, 3100, 3200, 1000, 2000, 1'b0);
    check_out(mk(0, 0, 0, 0, 0, 1'b0, 1'b0, 3000, 3200, 9300, 'b110, 1'b1, 1'b0, 'b0000));
    $display("txn init_normal: en=%0b sf=%0b bal=%b", b3.charge_en, b3.system_fault, b3.balance_en);

    // Eight cells at full scale must not overflow pack_sum.
    check("n8_ready", int'(b8.sample_ready), 1);
    b8.cell_voltage_bus = '1;
    b8.pack_current     = 12'd1000;
    b8.temperature      = 12'd2000;
    b8.sample_valid     = 1'b1;
    @(posedge clk); #1;
    b8.sample_valid = 1'b0;
    lat8 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (b8.result_valid === 1'b1) begin
        lat8 = i;
        break;
      end
    end
    check("n8_latency", lat8, 9);
    check("n8_pack_sum", int'(b8.pack_sum), 32760);
    check("n8_v_min", int'(b8.v_min), 4095);
    check("n8_v_max", int'(b8.v_max), 4095);
    check("n8_charge_en", int'(b8.charge_en), 0);
    $display("txn n8: sum=%0d vmin=%0d vmax=%0d", b8.pack_sum, b8.v_min, b8.v_max);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
